// File: rtl/operand_fetch_pkg.sv
// Shared defaults and FSM state type for the operand fetch stage.
package operand_fetch_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CNT_W_DEF  = 16;
  localparam int REG_ZERO   = 0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_STALL = 2'd2
  } of_state_e;

endpackage

// File: rtl/of_bypass_mux.sv
// Resolves one source operand from the zero register, EX/MEM bypasses or the register file.
module of_bypass_mux
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic [ADDR_W-1:0] idx,
  input  logic [DATA_W-1:0] rf_data,
  input  logic              ex_wen,
  input  logic              ex_load,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] data
);

  // A load in EX has no data yet; the hazard logic stalls instead of bypassing it.
  always_comb begin
    data = rf_data;
    if (idx == ADDR_W'(REG_ZERO))
      data = '0;
    else if (ex_wen && !ex_load && (ex_rd == idx))
      data = ex_data;
    else if (mem_wen && (mem_rd == idx))
      data = mem_data;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch stage: register-file read, EX/MEM forwarding, load-use stall, one-entry output register.
//
// state    | meaning
// ST_EMPTY | output register holds no bundle
// ST_FULL  | output register holds a valid bundle for EX
// ST_STALL | load-use hazard pending, output register drained
module operand_fetch
  import operand_fetch_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic              in_wen,
  input  logic              in_load,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  input  logic              ex_wen,
  input  logic              ex_load,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_wen,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_op1,
  output logic [DATA_W-1:0] out_op2,
  output logic [ADDR_W-1:0] out_rd,
  output logic              out_wen,
  output logic              out_load,
  output logic [CNT_W-1:0]  stall_cnt
);

  of_state_e         state;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] op1;
  logic [DATA_W-1:0] op2;

  assign rf_raddr1 = in_rs;
  assign rf_raddr2 = in_rt;

  assign hazard = in_valid & ex_wen & ex_load & (ex_rd != ADDR_W'(REG_ZERO)) &
                  ((ex_rd == in_rs) | (ex_rd == in_rt));
  assign out_valid = (state == ST_FULL);
  assign in_ready  = !hazard & (!out_valid | out_ready);
  assign accept    = in_valid & in_ready;

  of_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux1 (
    .idx(in_rs), .rf_data(rf_rdata1),
    .ex_wen(ex_wen), .ex_load(ex_load), .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data),
    .data(op1)
  );

  of_bypass_mux #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_mux2 (
    .idx(in_rt), .rf_data(rf_rdata2),
    .ex_wen(ex_wen), .ex_load(ex_load), .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data),
    .data(op2)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      out_op1   <= '0;
      out_op2   <= '0;
      out_rd    <= '0;
      out_wen   <= 1'b0;
      out_load  <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (hazard && (stall_cnt != '1))
        stall_cnt <= stall_cnt + 1'b1;
      if (accept) begin
        state    <= ST_FULL;
        out_op1  <= op1;
        out_op2  <= op2;
        out_rd   <= in_rd;
        out_wen  <= in_wen;
        out_load <= in_load;
      end else if (state != ST_FULL || out_ready) begin
        // Bubble: nothing accepted and the held bundle (if any) has been taken.
        state <= hazard ? ST_STALL : ST_EMPTY;
      end
    end
  end

endmodule

// File: tb/tb_operand_fetch.sv
// Directed bench for operand_fetch: forwarding priority, load-use stall, backpressure and async reset.
module tb_operand_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [4:0]  in_rs, in_rt, in_rd;
  logic        in_wen, in_load;
  logic [4:0]  rf_raddr1, rf_raddr2;
  logic [31:0] rf_rdata1, rf_rdata2;
  logic        ex_wen, ex_load;
  logic [4:0]  ex_rd;
  logic [31:0] ex_data;
  logic        mem_wen;
  logic [4:0]  mem_rd;
  logic [31:0] mem_data;
  logic        out_valid, out_ready;
  logic [31:0] out_op1, out_op2;
  logic [4:0]  out_rd;
  logic        out_wen, out_load;
  logic [15:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  operand_fetch dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_wen(in_wen), .in_load(in_load),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2),
    .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
    .ex_wen(ex_wen), .ex_load(ex_load), .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_wen(mem_wen), .mem_rd(mem_rd), .mem_data(mem_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_op1(out_op1), .out_op2(out_op2), .out_rd(out_rd),
    .out_wen(out_wen), .out_load(out_load),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic wen, input logic ld,
                           input logic [31:0] d1, input logic [31:0] d2);
    in_valid  = 1'b1;
    in_rs     = rs;
    in_rt     = rt;
    in_rd     = rd;
    in_wen    = wen;
    in_load   = ld;
    rf_rdata1 = d1;
    rf_rdata2 = d2;
  endtask

  task automatic set_fwd(input logic ew, input logic el, input logic [4:0] erd, input logic [31:0] ed,
                         input logic mw, input logic [4:0] mrd, input logic [31:0] md);
    ex_wen   = ew;
    ex_load  = el;
    ex_rd    = erd;
    ex_data  = ed;
    mem_wen  = mw;
    mem_rd   = mrd;
    mem_data = md;
  endtask

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    set_instr(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0);
    in_valid = 1'b0;
    set_fwd(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_stall_cnt", 64'(stall_cnt), 64'd0);
    chk("rst_out_op1", 64'(out_op1), 64'd0);
    @(negedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Plain register-file read
    set_instr(5'd3, 5'd7, 5'd9, 1'b1, 1'b0, 32'h11, 32'h22);
    #1;
    chk("raddr1", 64'(rf_raddr1), 64'd3);
    chk("raddr2", 64'(rf_raddr2), 64'd7);
    chk("rf_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk("rf_valid", 64'(out_valid), 64'd1);
    chk("rf_op1", 64'(out_op1), 64'h11);
    chk("rf_op2", 64'(out_op2), 64'h22);
    chk("rf_rd", 64'(out_rd), 64'd9);
    chk("rf_wen", 64'(out_wen), 64'd1);
    chk("rf_load", 64'(out_load), 64'd0);

    // EX beats MEM on the same index
    set_instr(5'd4, 5'd6, 5'd1, 1'b0, 1'b0, 32'h44, 32'h66);
    set_fwd(1'b1, 1'b0, 5'd4, 32'hAA, 1'b1, 5'd4, 32'hBB);
    tick();
    chk("exmem_op1", 64'(out_op1), 64'hAA);
    chk("exmem_op2", 64'(out_op2), 64'h66);

    // Separate EX and MEM hits on the two operands
    set_instr(5'd10, 5'd12, 5'd2, 1'b0, 1'b0, 32'h1010, 32'h1212);
    set_fwd(1'b1, 1'b0, 5'd12, 32'hC0, 1'b1, 5'd10, 32'hD0);
    tick();
    chk("mem_op1", 64'(out_op1), 64'hD0);
    chk("ex_op2", 64'(out_op2), 64'hC0);

    // Load-use hazard on rt
    set_instr(5'd1, 5'd5, 5'd3, 1'b1, 1'b0, 32'h01, 32'h55);
    set_fwd(1'b1, 1'b1, 5'd5, 32'hDEAD, 1'b0, 5'd0, 32'h0);
    #1;
    chk("haz_in_ready", 64'(in_ready), 64'd0);
    tick();
    chk("haz_stall_cnt1", 64'(stall_cnt), 64'd1);
    chk("haz_out_valid", 64'(out_valid), 64'd0);
    chk("haz_in_ready2", 64'(in_ready), 64'd0);
    tick();
    chk("haz_stall_cnt2", 64'(stall_cnt), 64'd2);
    set_fwd(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 32'h5A);
    #1;
    chk("haz_release_ready", 64'(in_ready), 64'd1);
    tick();
    chk("haz_acc_valid", 64'(out_valid), 64'd1);
    chk("haz_acc_op1", 64'(out_op1), 64'h01);
    chk("haz_acc_op2", 64'(out_op2), 64'h5A);
    chk("haz_cnt_hold", 64'(stall_cnt), 64'd2);

    // Register zero: never forwarded, never a hazard
    set_instr(5'd0, 5'd0, 5'd4, 1'b1, 1'b0, 32'h77, 32'h78);
    set_fwd(1'b1, 1'b0, 5'd0, 32'hFF, 1'b0, 5'd0, 32'h0);
    tick();
    chk("zero_op1", 64'(out_op1), 64'd0);
    chk("zero_op2", 64'(out_op2), 64'd0);
    set_fwd(1'b1, 1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
    #1;
    chk("zero_load_ready", 64'(in_ready), 64'd1);
    tick();
    chk("zero_load_cnt", 64'(stall_cnt), 64'd2);

    // Idle with a hazard-looking EX: inert, bubble drains output
    in_valid = 1'b0;
    in_rs    = 5'd5;
    set_fwd(1'b1, 1'b1, 5'd5, 32'h0, 1'b0, 5'd0, 32'h0);
    #1;
    chk("idle_ready", 64'(in_ready), 64'd1);
    tick();
    chk("idle_bubble", 64'(out_valid), 64'd0);
    chk("idle_cnt", 64'(stall_cnt), 64'd2);

    // Backpressure holds the bundle
    set_fwd(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    set_instr(5'd2, 5'd3, 5'd7, 1'b1, 1'b1, 32'h12, 32'h13);
    tick();
    out_ready = 1'b0;
    set_instr(5'd20, 5'd21, 5'd8, 1'b0, 1'b0, 32'h34, 32'h35);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_in_ready", 64'(in_ready), 64'd0);
      tick();
      chk("bp_valid", 64'(out_valid), 64'd1);
      chk("bp_op1", 64'(out_op1), 64'h12);
      chk("bp_op2", 64'(out_op2), 64'h13);
      chk("bp_ctl", 64'({out_rd, out_wen, out_load}), 64'({5'd7, 1'b1, 1'b1}));
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 64'(in_ready), 64'd1);
    tick();
    chk("bp_next_op1", 64'(out_op1), 64'h34);
    chk("bp_next_ctl", 64'({out_rd, out_wen, out_load}), 64'({5'd8, 1'b0, 1'b0}));

    // Asynchronous reset mid-FULL, away from any clock edge
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_cnt", 64'(stall_cnt), 64'd0);
    chk("arst_op1", 64'(out_op1), 64'd0);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("arst_still_empty", 64'(out_valid), 64'd0);
    set_instr(5'd6, 5'd7, 5'd11, 1'b1, 1'b0, 32'h66, 32'h67);
    tick();
    chk("arst_accept_op1", 64'(out_op1), 64'h66);
    chk("arst_accept_valid", 64'(out_valid), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
OPERAND_FETCH -- requirements
Module: operand_fetch

Interface
REQ-001 SHALL have parameter DATA_W, default 32, operand width.
REQ-002 SHALL have parameter ADDR_W, default 5, register index width (32 registers).
REQ-003 SHALL have parameter CNT_W, default 16, stall-counter width.
REQ-004 SHALL have ports as listed:
- clk  in  1  single clock, all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  decoded instruction present.
- in_ready  out  1  stage accepts the instruction this cycle.
- in_rs, in_rt, in_rd  in  ADDR_W  source 1, source 2 and destination indices.
- in_wen, in_load  in  1  instruction writes rd; instruction is a load.
- rf_raddr1, rf_raddr2  out  ADDR_W  register-file read addresses.
- rf_rdata1, rf_rdata2  in  DATA_W  register-file combinational read data.
- ex_wen, ex_load  in  1  EX-stage instruction writes rd; EX-stage instruction is a load.
- ex_rd  in  ADDR_W  EX-stage destination.
- ex_data  in  DATA_W  EX-stage ALU result.
- mem_wen  in  1  MEM-stage instruction writes rd.
- mem_rd  in  ADDR_W  MEM-stage destination.
- mem_data  in  DATA_W  MEM-stage result.
- out_valid  out  1  operand bundle valid.
- out_ready  in  1  EX stage accepts the bundle.
- out_op1, out_op2  out  DATA_W  resolved operands.
- out_rd  out  ADDR_W  destination, passed through.
- out_wen, out_load  out  1  passed-through control.
- stall_cnt  out  CNT_W  load-use stall cycles.

Function
REQ-005 SHALL drive rf_raddr1 = in_rs and rf_raddr2 = in_rt combinationally.
REQ-006 SHALL resolve each operand with this priority: index 0 -> 0; EX match (ex_wen, ex_rd == idx, !ex_load) -> ex_data; MEM match (mem_wen, mem_rd == idx) -> mem_data; otherwise rf_rdata.
REQ-007 SHALL provide no writeback bypass, because the register file writes on negedge and the value is visible by the next posedge.
REQ-008 SHALL assert hazard = in_valid & ex_wen & ex_load & ex_rd != 0 & (ex_rd == in_rs | ex_rd == in_rt).
REQ-009 SHALL drive in_ready = !hazard & (!out_valid | out_ready).
REQ-010 SHALL load the output register on posedge when in_valid & in_ready: out_valid = 1 and all operand and control fields captured; latency is 1 cycle.
REQ-011 SHALL clear out_valid (bubble) on posedge when out_ready and no new instruction is accepted, including during a hazard.
REQ-012 SHALL hold all output fields stable while out_valid & !out_ready (backpressure).
REQ-013 SHALL implement a 3-state FSM:
- EMPTY: out_valid = 0.
- FULL: out_valid = 1.
- STALL: hazard with the output drained.
- Transitions follow REQ-010 and REQ-011; STALL goes to FULL when hazard deasserts and the instruction is accepted.
REQ-014 SHALL increment stall_cnt on every posedge with hazard = 1, saturating at all ones.
REQ-015 SHALL ignore in_wen and in_load for forwarding; they are passed through only.
REQ-016 SHALL be inert when in_valid = 0: no hazard, no stall count.

Reset
REQ-017 SHALL, while rst_n = 0, asynchronously force these outputs to 0: out_valid, out_op1, out_op2, out_rd, out_wen, out_load, stall_cnt; FSM state = EMPTY.
REQ-018 SHALL discard an in-flight bundle on reset mid-operation, and SHALL accept the first instruction no earlier than the first posedge after rst_n rises.

Structure
REQ-019 SHALL place DATA_W, ADDR_W, CNT_W defaults, REG_ZERO = 0 and the FSM state enum in a shared package, operand_fetch_pkg.
REQ-020 SHALL instantiate the sub-module of_bypass_mux twice, once per operand, each implementing REQ-006.

Verification
REQ-021 Bench SHALL check: rs = 3, rf_rdata1 = 0x11, no matches -> out_op1 = 0x11 one cycle after accept.
REQ-022 Bench SHALL check: rs = 4, ex_rd = 4 with ex_data = 0xAA, mem_rd = 4 with mem_data = 0xBB -> out_op1 = 0xAA.
REQ-023 Bench SHALL check: rt = 5, ex_load = 1, ex_rd = 5 -> in_ready = 0, stall_cnt = 1, out_valid = 0 next cycle; EX drops the load -> accepted, out_op2 = forwarded/rf value.
REQ-024 Bench SHALL check: rs = 0, ex_rd = 0, ex_wen = 1, ex_data = 0xFF -> out_op1 = 0, no hazard.
REQ-025 Bench SHALL check: out_ready = 0 for 3 cycles while out_valid = 1 -> outputs constant, in_ready = 0; out_ready = 1 -> next bundle accepted.
REQ-026 Bench SHALL check: rst_n pulsed low mid-FULL -> out_valid = 0 and stall_cnt = 0 immediately, without waiting for a clock edge.
